uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Receive half of the on-chip UART. Deserialises 8N1 frames (start 0, 8 data bits LSB first, stop 1) from a single serial line into bytes for the CPU/host logic.
- Bit timing is set by CLKS_PER_BIT. The default of 1 matches the uart_sender timing of one bit per clk, so the two blocks can be wired back-to-back.
- Received bytes go into a one-byte holding register with a valid/ack handshake. Overrun and framing errors are reported.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit (>=1). Sample offset within a bit: HALF = (CLKS_PER_BIT-1)/2, integer division.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line; idles high
- rx_ack  input  1  consumer acknowledges rx_data; sampled on clk edges
- rx_data  output  8  last accepted byte
- rx_valid  output  1  rx_data holds an unacknowledged byte
- overrun  output  1  sticky: a completed byte was dropped because rx_valid was set
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- busy  output  1  high while a frame is in progress (any state except IDLE/ARM)

Behaviour:
- Reset (async, any state, including mid-frame):
  - rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0.
  - State goes to ARM. Any partial frame is discarded.
- States:
  - ARM: wait for the sampled line (rx_s) to be 1, then go to IDLE. This prevents a held-low line (break, or low at reset) from being read as a start bit.
  - IDLE: rx_s==0 marks cycle 0 of the start bit. Go to START with the bit counter and cycle counter cleared.
  - START, DATA, STOP: bit k (0=start, 1..8=data, 9=stop) is sampled at cycle k*CLKS_PER_BIT+HALF after the detection cycle. With CLKS_PER_BIT=1, this is cycles 0..9, one bit per clk.
  - START check: if the start sample reads 1, treat it as a glitch and return to IDLE. No outputs change.
  - DATA: data bit n is shifted into the shift register at bit position n (LSB first).
  - STOP: after the stop-bit sample, go to IDLE. Exception: if the stop bit was 0, go to ARM.
- Stop bit = 1, on the same edge that samples it:
  - If rx_valid==0, or rx_ack==1 on that edge: load rx_data and set rx_valid=1.
  - Otherwise: keep the old rx_data, set overrun=1, and leave rx_valid at 1.
- Stop bit = 0: frame_err=1 for exactly one cycle. The byte is discarded. rx_data and rx_valid are unchanged.
- Handshake:
  - rx_ack==1 on an edge clears rx_valid and overrun, unless a new byte loads on the same edge. In that case rx_valid stays 1 and overrun is cleared.
  - rx_ack while rx_valid==0 is ignored.
- A new start bit can be detected on the first cycle after the stop sample if rx_s is 0 there. A stop bit shorter than one full bit is accepted.
- Back-to-back frames from uart_sender are received without loss provided each byte is acked before the next stop bit.
- Counter widths: bit counter 4 bits; cycle counter clog2(CLKS_PER_BIT)+1 bits. No wrap is reachable within a frame.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined:
  - rx passes through a 2-flop synchroniser before use as rx_s. Both flops reset to 1.
  - All sample points, and the rx_valid/frame_err timing, move 2 clk later relative to the rx pin.
  - Required when rx is asynchronous to clk.
- Undefined:
  - rx_s = rx directly, for same-clock sources such as uart_sender.

Test Plan:
- Loopback with uart_sender, CLKS_PER_BIT=1, send 0xA5:
  - rx_data=0xA5, rx_valid=1 on the edge sampling the stop bit (10th cycle after the start bit first appears), 12 clk with UART_RX_SYNC_EN.
  - overrun=0, frame_err=0.
- CLKS_PER_BIT=16, drive 0x3C frame; then a 5-cycle low glitch on an idle line:
  - 0x3C received.
  - The glitch returns to IDLE with no rx_valid and no frame_err.
- Receive 0x11 with no ack, then 0x22:
  - rx_data stays 0x11, overrun=1.
  - rx_ack clears rx_valid and overrun.
  - Same test with rx_ack on the 0x22 stop edge: rx_data=0x22, rx_valid=1, overrun=0.
- Frame 0x55 with stop bit forced 0, line then held low 20 cycles:
  - frame_err pulses once.
  - rx_valid stays 0.
  - No new frame until rx returns high; the next 0x0F frame is received correctly.
- Assert rst during data bit 4 of 0xFF:
  - All outputs 0 immediately (async).
  - After release, the partial frame is not reported and the next full frame 0x81 is received.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Serial receive bus: line and ack in, received byte and status out.
// master = receiver side, slave = line driver / byte consumer side.
interface uart_receiver_if;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx, rx_ack,
        output rx_data, rx_valid, overrun, frame_err, busy
    );

    modport slave (
        output rx, rx_ack,
        input  rx_data, rx_valid, overrun, frame_err, busy
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-byte holding register, overrun and framing-error reporting.
// Optional `UART_RX_SYNC_EN adds a 2-flop input synchroniser for asynchronous rx.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_receiver_if.master bus
);

    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BW   = 4;

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} state_e;

    state_e        state_q;
    logic [BW-1:0] bit_q;
    logic [CW-1:0] cyc_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ovr_q;
    logic          ferr_q;
    logic          busy_q;
    logic          rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.rx};
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = bus.rx;
`endif

    // Position within the frame; the IDLE detection edge counts as bit 0, cycle 0.
    logic          active_c;
    logic          sample_c;
    logic          last_c;
    logic [BW-1:0] bit_c;
    logic [CW-1:0] cyc_c;
    logic          stop_ok_c;
    logic          stop_bad_c;
    logic          ack_c;
    logic          load_c;
    logic          drop_c;
    logic          valid_d;
    logic          ovr_d;

    always_comb begin
        active_c = 1'b0;
        bit_c    = '0;
        cyc_c    = '0;
        case (state_q)
            IDLE:             active_c = !rx_s;
            START, DATA, STOP: begin
                active_c = 1'b1;
                bit_c    = bit_q;
                cyc_c    = cyc_q;
            end
            default: ;
        endcase
        sample_c   = active_c && (cyc_c == CW'(HALF));
        last_c     = (cyc_c == CW'(CLKS_PER_BIT - 1));
        stop_ok_c  = sample_c && (bit_c == 4'd9) && rx_s;
        stop_bad_c = sample_c && (bit_c == 4'd9) && !rx_s;
        ack_c      = bus.rx_ack && valid_q;
        load_c     = stop_ok_c && (!valid_q || bus.rx_ack);
        drop_c     = stop_ok_c && valid_q && !bus.rx_ack;
        valid_d    = load_c ? 1'b1 : (ack_c ? 1'b0 : valid_q);
        ovr_d      = drop_c ? 1'b1 : (ack_c ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARM;
            bit_q   <= '0;
            cyc_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= stop_bad_c;
            if (load_c) data_q <= shift_q;

            case (state_q)
                // A line held low must return high before a start bit is trusted.
                ARM: begin
                    busy_q <= 1'b0;
                    if (rx_s) state_q <= IDLE;
                end
                default: begin
                    if (active_c) begin
                        if (sample_c && (bit_c == 4'd0) && rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else if (sample_c && (bit_c == 4'd9)) begin
                            state_q <= rx_s ? IDLE : ARM;
                            busy_q  <= 1'b0;
                        end else begin
                            busy_q <= 1'b1;
                            if (sample_c && (bit_c != 4'd0)) shift_q[3'(bit_c - 4'd1)] <= rx_s;
                            if (last_c) begin
                                cyc_q   <= '0;
                                bit_q   <= bit_c + 4'd1;
                                state_q <= (bit_c == 4'd8) ? STOP : DATA;
                            end else begin
                                cyc_q <= cyc_c + CW'(1);
                                bit_q <= bit_c;
                                if (state_q == IDLE) state_q <= START;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: two instances (1 and 16 clk/bit), directed and random frames.
module tb_uart_receiver;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int K_LOAD = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    typedef struct {
        int         dev;
        int         kind;
        logic [7:0] data;
        logic       ovr;
        longint     cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rx_l;
    logic [1:0] ack_l;
    logic [1:0] ack_s;
    logic [1:0] vld, ovr, fer, bsy;
    logic [7:0] dat [2];
    logic [1:0] pv, po;
    logic [1:0] mv, mo;
    longint     cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       sb[$];
    int         ack_dev = -1;
    longint     ack_edge = -1;

    uart_receiver_if if0 ();
    uart_receiver_if if1 ();

    uart_receiver #(.CLKS_PER_BIT(1))  u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    uart_receiver #(.CLKS_PER_BIT(16)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    assign if0.rx = rx_l[0];
    assign if1.rx = rx_l[1];
    assign if0.rx_ack = ack_l[0];
    assign if1.rx_ack = ack_l[1];
    assign vld = {if1.rx_valid, if0.rx_valid};
    assign ovr = {if1.overrun, if0.overrun};
    assign fer = {if1.frame_err, if0.frame_err};
    assign bsy = {if1.busy, if0.busy};
    assign dat[0] = if0.rx_data;
    assign dat[1] = if1.rx_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ack_s <= ack_l;
    end

    function automatic int cpb(input int d);
        return (d == 0) ? 1 : 16;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    task automatic got_event(input int d, input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event dev=%0d kind=%0d got=event exp=none at cycle %0d", d, kind, cyc);
        end else begin
            e = sb.pop_front();
            chk("ev_dev", 64'(d), 64'(e.dev));
            chk("ev_kind", 64'(kind), 64'(e.kind));
            chk("ev_cycle", 64'(cyc), 64'(e.cyc));
            if (kind == K_LOAD) begin
                chk("ev_data", 64'(dat[d]), 64'(e.data));
                chk("ev_overrun", 64'(ovr[d]), 64'(e.ovr));
            end
        end
    endtask

    // Monitor: a byte load, a framing error or a new overrun is an observable event.
    always @(negedge clk) begin
        if (rst) begin
            pv <= '0;
            po <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (vld[d] && (!pv[d] || ack_s[d])) got_event(d, K_LOAD);
                if (fer[d])                         got_event(d, K_FERR);
                if (ovr[d] && !po[d])               got_event(d, K_OVR);
            end
            pv <= vld;
            po <= ovr;
        end
    end

    task automatic step();
        if (ack_dev >= 0 && (cyc + 1) == ack_edge) ack_l[ack_dev] = 1'b1;
        @(posedge clk);
        #1;
        ack_l = '0;
    endtask

    task automatic do_ack(input int d);
        ack_l[d] = 1'b1;
        @(posedge clk);
        #1;
        ack_l = '0;
        mv[d] = 1'b0;
        mo[d] = 1'b0;
    endtask

    // Drives one frame and predicts its outcome from the holding-register model.
    task automatic send(input int d, input logic [7:0] b, input logic stopb, input logic ack_stop);
        logic [9:0] bits;
        exp_t       e;
        longint     se;
        int         c;
        bit         push;
        c    = cpb(d);
        bits = {stopb, b, 1'b0};
        se   = cyc + 1 + 9 * c + (c - 1) / 2 + SYNC;
        push = 1'b1;
        e.dev = d;
        e.cyc = se;
        e.data = b;
        if (!stopb) begin
            e.kind = K_FERR;
            if (ack_stop && mv[d]) begin
                mv[d] = 1'b0;
                mo[d] = 1'b0;
            end
        end else if (!mv[d] || ack_stop) begin
            e.kind = K_LOAD;
            mv[d]  = 1'b1;
            if (ack_stop) mo[d] = 1'b0;
        end else begin
            e.kind = K_OVR;
            push   = !mo[d];
            mo[d]  = 1'b1;
        end
        e.ovr = mo[d];
        if (push) sb.push_back(e);
        ack_dev  = ack_stop ? d : -1;
        ack_edge = se;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < c; j++) begin
                rx_l[d] = bits[k];
                if (k == 5 && j == 0) chk("busy_mid_frame", 64'(bsy[d]), 64'd1);
                step();
            end
        end
        while (cyc < se) step();
        ack_dev = -1;
    endtask

    initial begin
        rst   = 1'b1;
        rx_l  = '1;
        ack_l = '0;
        mv    = '0;
        mo    = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_data", 64'(dat[d]), 64'd0);
            chk("rst_valid", 64'(vld[d]), 64'd0);
            chk("rst_overrun", 64'(ovr[d]), 64'd0);
            chk("rst_frame_err", 64'(fer[d]), 64'd0);
            chk("rst_busy", 64'(bsy[d]), 64'd0);
        end
        rst = 1'b0;
        repeat (4) step();

        // Loopback-style frame at one bit per clk
        send(0, 8'hA5, 1'b1, 1'b0);
        chk("a5_data", 64'(dat[0]), 64'hA5);
        chk("a5_valid", 64'(vld[0]), 64'd1);
        chk("a5_overrun", 64'(ovr[0]), 64'd0);
        do_ack(0);
        chk("a5_ack_valid", 64'(vld[0]), 64'd0);

        // 16 clk/bit frame, then a short low glitch on idle
        send(1, 8'h3C, 1'b1, 1'b0);
        chk("3c_data", 64'(dat[1]), 64'h3C);
        do_ack(1);
        rx_l[1] = 1'b0;
        repeat (5) step();
        rx_l[1] = 1'b1;
        repeat (40) step();
        chk("glitch_busy", 64'(bsy[1]), 64'd0);
        chk("glitch_valid", 64'(vld[1]), 64'd0);

        // Overrun without ack, then ack clears it
        send(0, 8'h11, 1'b1, 1'b0);
        send(0, 8'h22, 1'b1, 1'b0);
        chk("ovr_data_kept", 64'(dat[0]), 64'h11);
        chk("ovr_set", 64'(ovr[0]), 64'd1);
        chk("ovr_valid", 64'(vld[0]), 64'd1);
        do_ack(0);
        chk("ovr_ack_valid", 64'(vld[0]), 64'd0);
        chk("ovr_ack_overrun", 64'(ovr[0]), 64'd0);

        // Ack on the stop edge lets the new byte load
        send(0, 8'h11, 1'b1, 1'b0);
        send(0, 8'h22, 1'b1, 1'b1);
        chk("ackstop_data", 64'(dat[0]), 64'h22);
        chk("ackstop_valid", 64'(vld[0]), 64'd1);
        chk("ackstop_overrun", 64'(ovr[0]), 64'd0);
        do_ack(0);

        // Bad stop bit, line held low, then a good frame
        send(0, 8'h55, 1'b0, 1'b0);
        repeat (20) step();
        chk("ferr_valid", 64'(vld[0]), 64'd0);
        chk("ferr_busy_low", 64'(bsy[0]), 64'd0);
        chk("ferr_pulse_gone", 64'(fer[0]), 64'd0);
        rx_l[0] = 1'b1;
        repeat (2) step();
        send(0, 8'h0F, 1'b1, 1'b0);
        chk("0f_data", 64'(dat[0]), 64'h0F);

        // Async reset during data bit 4 of 0xFF
        rx_l[0] = 1'b0;
        step();
        rx_l[0] = 1'b1;
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_data", 64'(dat[0]), 64'd0);
        chk("arst_valid", 64'(vld[0]), 64'd0);
        chk("arst_busy", 64'(bsy[0]), 64'd0);
        chk("arst_overrun", 64'(ovr[0]), 64'd0);
        mv = '0;
        mo = '0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        rx_l = '1;
        repeat (3) step();
        send(0, 8'h81, 1'b1, 1'b0);
        chk("81_data", 64'(dat[0]), 64'h81);
        do_ack(0);

        // Random frames on both receivers
        for (int i = 0; i < 40; i++) begin
            int         d;
            logic [7:0] b;
            logic       stopb;
            logic       ak;
            d     = int'($urandom_range(0, 1));
            b     = 8'($urandom);
            stopb = ($urandom_range(0, 7) != 0);
            ak    = 1'($urandom_range(0, 1));
            send(d, b, stopb, ak);
            if (!stopb) begin
                rx_l[d] = 1'b1;
                step();
            end
            if ($urandom_range(0, 1) == 1) do_ack(d);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (SYNC + 3) step();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
